// File: rtl/sdram_arb_pkg.sv
// Shared types and default timing for the SDRAM port arbiter.
package sdram_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  // Controller operation issued on a grant.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RF   = 2'd1,
    OP_RD   = 2'd2,
    OP_WR   = 2'd3
  } op_t;

  // Requester that owns the current grant.
  typedef enum logic [1:0] {
    SRC_RF = 2'd0,
    SRC_A  = 2'd1,
    SRC_B  = 2'd2
  } src_t;

  // Clocks one controller op occupies, counted from its strobe cycle.
  localparam int TCYC_DEF = 8;
  // Clocks from the strobe cycle to the cycle the controller's read data is valid.
  localparam int TQ_DEF   = 5;

endpackage

// File: rtl/sdram_arb_pend.sv
// One-deep pulse-to-pending latch with payload. A set pulse always wins over a clear
// in the same cycle, so a request landing on the consume cycle is never dropped; a
// newer pulse overwrites the payload of an older unconsumed one.
module sdram_arb_pend #(
  parameter int PW = 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          set_i,
  input  logic          clr_i,
  input  logic [PW-1:0] data_i,
  output logic          pend_o,
  output logic [PW-1:0] data_o
);

  logic          pend_q;
  logic [PW-1:0] data_q;

  // Pending flag and payload: set (with capture) has priority over clear.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else if (set_i) begin
      pend_q <= 1'b1;
      data_q <= data_i;
    end else if (clr_i) begin
      pend_q <= 1'b0;
    end
  end

  assign pend_o = pend_q;
  assign data_o = data_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between refresh, the CPU bus (port A, pulses) and a
// DMA/loader master (port B, req/ack). Fixed priority refresh > A > B, one op at a time.
//
// Handshakes: A requests are single-clock aRd/aWr pulses latched into a pending slot;
// aVal pulses for one clock when aQ carries fresh read data. B holds bReq with stable
// fields; bReq is looked at only in IDLE, and bAck pulses for one clock when the op is
// done (bQ valid in that same cycle for reads). The master drops bReq or presents the
// next op in the cycle after bAck. Controller strobes are one clock wide.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW   = 24,
  parameter int DW   = 16,
  parameter int TCYC = TCYC_DEF,
  parameter int TQ   = TQ_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rfReq,
  input  logic          aRd,
  input  logic          aWr,
  input  logic [AW-1:0] aA,
  input  logic [DW-1:0] aD,
  output logic [DW-1:0] aQ,
  output logic          aVal,
  input  logic          bReq,
  input  logic          bWe,
  input  logic [AW-1:0] bA,
  input  logic [DW-1:0] bD,
  output logic          bAck,
  output logic [DW-1:0] bQ,
  output logic          sdrRf,
  output logic          sdrRd,
  output logic          sdrWr,
  output logic [AW-1:0] sdrA,
  output logic [DW-1:0] sdrD,
  input  logic [DW-1:0] sdrQ,
  output logic          busy,
  output state_t        dbgState
);

  localparam int             CW       = $clog2(TCYC + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TCYC - 1);
  localparam logic [CW-1:0]  CNT_CAP  = CW'(TQ);
  localparam int             APW      = 1 + AW + DW;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  op_t           op_q;
  src_t          src_q;
  logic          busy_q;
  logic          sdr_rf_q, sdr_rd_q, sdr_wr_q;
  logic [AW-1:0] sdr_a_q;
  logic [DW-1:0] sdr_d_q;
  logic [DW-1:0] a_q_q, b_q_q;

  logic           rf_pend, a_pend;
  logic [1:0]     rf_op;
  logic [APW-1:0] a_pay;
  logic           a_pay_wr;
  logic [AW-1:0]  a_pay_addr;
  logic [DW-1:0]  a_pay_data;
  logic           in_idle, rf_clr, a_clr, b_go, cap;

  assign in_idle = (state_q == IDLE);
  assign rf_clr  = in_idle & rf_pend;
  assign a_clr   = in_idle & ~rf_pend & a_pend;
  // A pulse arriving this cycle outranks B next cycle, so B waits one IDLE clock for it.
  assign b_go    = in_idle & ~rf_pend & ~a_pend & bReq & ~(rfReq | aRd | aWr);

  sdram_arb_pend #(.PW(2)) u_rf_pend (
    .clk_i   (clock),
    .rst_n_i (reset),
    .set_i   (rfReq),
    .clr_i   (rf_clr),
    .data_i  (OP_RF),
    .pend_o  (rf_pend),
    .data_o  (rf_op)
  );

  // Write wins when both pulses arrive together.
  sdram_arb_pend #(.PW(APW)) u_a_pend (
    .clk_i   (clock),
    .rst_n_i (reset),
    .set_i   (aRd | aWr),
    .clr_i   (a_clr),
    .data_i  ({aWr, aA, aD}),
    .pend_o  (a_pend),
    .data_o  (a_pay)
  );

  assign a_pay_wr   = a_pay[APW-1];
  assign a_pay_addr = a_pay[AW+DW-1:DW];
  assign a_pay_data = a_pay[DW-1:0];

  // Arbitration FSM with registered strobes, controller address/data and read capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_NONE;
      src_q    <= SRC_RF;
      busy_q   <= 1'b0;
      sdr_rf_q <= 1'b0;
      sdr_rd_q <= 1'b0;
      sdr_wr_q <= 1'b0;
      sdr_a_q  <= '0;
      sdr_d_q  <= '0;
      a_q_q    <= '0;
      b_q_q    <= '0;
    end else begin
      sdr_rf_q <= 1'b0;
      sdr_rd_q <= 1'b0;
      sdr_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rf_pend) begin
            state_q  <= GRANT;
            busy_q   <= 1'b1;
            src_q    <= SRC_RF;
            op_q     <= op_t'(rf_op);
            sdr_rf_q <= 1'b1;
          end else if (a_pend) begin
            state_q  <= GRANT;
            busy_q   <= 1'b1;
            src_q    <= SRC_A;
            op_q     <= a_pay_wr ? OP_WR : OP_RD;
            sdr_wr_q <= a_pay_wr;
            sdr_rd_q <= ~a_pay_wr;
            sdr_a_q  <= a_pay_addr;
            sdr_d_q  <= a_pay_data;
          end else if (b_go) begin
            state_q  <= GRANT;
            busy_q   <= 1'b1;
            src_q    <= SRC_B;
            op_q     <= bWe ? OP_WR : OP_RD;
            sdr_wr_q <= bWe;
            sdr_rd_q <= ~bWe;
            sdr_a_q  <= bA;
            sdr_d_q  <= bD;
          end
        end
        GRANT: begin
          state_q <= BUSY;
          cnt_q   <= CW'(1);
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            op_q    <= OP_NONE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (cap && src_q == SRC_A && op_q == OP_RD) a_q_q <= sdrQ;
      if (cap && src_q == SRC_B && op_q == OP_RD) b_q_q <= sdrQ;
    end
  end

  // Capture cycle is TQ clocks after the strobe; read data bypasses the holding register.
  assign cap   = (state_q == BUSY) && (cnt_q == CNT_CAP);
  assign aVal  = cap && (src_q == SRC_A) && (op_q == OP_RD);
  assign bAck  = cap && (src_q == SRC_B);
  assign aQ    = aVal ? sdrQ : a_q_q;
  assign bQ    = (bAck && op_q == OP_RD) ? sdrQ : b_q_q;

  assign sdrRf    = sdr_rf_q;
  assign sdrRd    = sdr_rd_q;
  assign sdrWr    = sdr_wr_q;
  assign sdrA     = sdr_a_q;
  assign sdrD     = sdr_d_q;
  assign busy     = busy_q;
  assign dbgState = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus a randomized mixed-traffic run,
// with a behavioural controller that returns address-derived read data TQ clocks
// after each read strobe.
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int AW     = 24;
  localparam int DW     = 16;
  localparam int TCYC   = 8;
  localparam int TQ     = 5;
  localparam int PERIOD = TCYC + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          rfReq = 1'b0;
  logic          aRd = 1'b0, aWr = 1'b0;
  logic [AW-1:0] aA = '0;
  logic [DW-1:0] aD = '0;
  logic [DW-1:0] aQ;
  logic          aVal;
  logic          bReq = 1'b0, bWe = 1'b0;
  logic [AW-1:0] bA = '0;
  logic [DW-1:0] bD = '0;
  logic          bAck;
  logic [DW-1:0] bQ;
  logic          sdrRf, sdrRd, sdrWr;
  logic [AW-1:0] sdrA;
  logic [DW-1:0] sdrD;
  logic [DW-1:0] sdrQ = '0;
  logic          busy;
  state_t        dbgState;

  sdram_arbiter #(.AW(AW), .DW(DW), .TCYC(TCYC), .TQ(TQ)) dut (
    .clock(clock), .reset(reset), .rfReq(rfReq),
    .aRd(aRd), .aWr(aWr), .aA(aA), .aD(aD), .aQ(aQ), .aVal(aVal),
    .bReq(bReq), .bWe(bWe), .bA(bA), .bD(bD), .bAck(bAck), .bQ(bQ),
    .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrA(sdrA), .sdrD(sdrD),
    .sdrQ(sdrQ), .busy(busy), .dbgState(dbgState)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- controller model + monitor ----------------
  typedef struct {
    int            cyc;
    op_t           kind;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } strobe_t;

  strobe_t       slog[$];
  logic [AW-1:0] exp_q[$];
  int            cyc = 0;
  int            last_strobe = -1000;
  int            rd_age = 1000;
  logic [AW-1:0] rd_addr = '0;
  bit            prev_strobe = 0, prev_aval = 0, prev_back = 0;
  int            aval_cnt = 0, back_cnt = 0;
  int            last_aval_cyc = 0, last_back_cyc = 0;
  bit            sb_on = 0;
  bit            force_en = 0;
  logic [DW-1:0] force_val = '0;

  // Memory contents as seen by the bench: a fixed scramble of the address.
  function automatic logic [DW-1:0] model_q(input logic [AW-1:0] a);
    if (force_en) return force_val;
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5AC3;
  endfunction

  always @(posedge clock) begin
    strobe_t s;
    cyc++;
    #1;
    if (sdrRf || sdrRd || sdrWr) begin
      check("strobe_onehot", 32'(int'(sdrRf) + int'(sdrRd) + int'(sdrWr)), 32'd1);
      check("strobe_1clk", {31'd0, prev_strobe}, 32'd0);
      check("strobe_gap", {31'd0, (cyc - last_strobe) >= PERIOD}, 32'd1);
      check("busy_at_strobe", {31'd0, busy}, 32'd1);
      s.cyc  = cyc;
      s.kind = sdrRf ? OP_RF : (sdrWr ? OP_WR : OP_RD);
      s.a    = sdrA;
      s.d    = sdrD;
      slog.push_back(s);
      last_strobe = cyc;
      if (sdrRd) begin
        rd_addr = sdrA;
        rd_age  = 0;
      end else begin
        rd_age = 1000;
      end
    end else if (rd_age < 1000) begin
      rd_age++;
    end
    prev_strobe = sdrRf | sdrRd | sdrWr;
    sdrQ = (rd_age == TQ) ? model_q(rd_addr) : DW'($urandom);
    #1;
    if (aVal) begin
      aval_cnt++;
      last_aval_cyc = cyc;
      check("aval_1clk", {31'd0, prev_aval}, 32'd0);
    end
    if (bAck) begin
      back_cnt++;
      last_back_cyc = cyc;
      check("back_1clk", {31'd0, prev_back}, 32'd0);
    end
    prev_aval = aVal;
    prev_back = bAck;
    if (sb_on) begin
      if (aVal) begin
        if (exp_q.size() == 0) check("sb_a_unexpected", 32'd1, 32'd0);
        else check("sb_a_rd_data", 32'(aQ), 32'(model_q(exp_q.pop_front())));
      end
      if (bAck) begin
        if (!bWe) begin
          check("sb_b_rd_data", 32'(bQ), 32'(model_q(bA)));
        end else begin
          check("sb_b_wr_kind", 32'(slog[$].kind), 32'(OP_WR));
          check("sb_b_wr_addr", 32'(slog[$].a), 32'(bA));
          check("sb_b_wr_data", 32'(slog[$].d), 32'(bD));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_a(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    aRd = !wr;
    aWr = wr;
    aA  = a;
    aD  = d;
    tick(1);
    aRd = 1'b0;
    aWr = 1'b0;
    aA  = AW'($urandom);
    aD  = DW'($urandom);
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (slog.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check({tag, "_strobe_timeout"}, {31'd0, slog.size() < n}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k, a0, b0, nb;
    bit got, a_done;
    logic [DW-1:0] bq_s;

    // Reset state
    reset = 1'b0;
    tick(3);
    check("rst_state", 32'(dbgState), 32'(IDLE));
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_strobes", {29'd0, sdrRf, sdrRd, sdrWr}, 32'd0);
    check("rst_pulses", {30'd0, aVal, bAck}, 32'd0);
    check("rst_aq", 32'(aQ), 32'd0);
    check("rst_bq", 32'(bQ), 32'd0);
    check("rst_sdra", 32'(sdrA), 32'd0);
    check("rst_sdrd", 32'(sdrD), 32'd0);
    reset = 1'b1;
    tick(2);

    // 1: single A read
    slog.delete();
    force_en  = 1'b1;
    force_val = 16'hBEEF;
    a0 = aval_cnt;
    pulse_a(1'b0, 24'h001234, 16'h0000);
    k = 0;
    while (aval_cnt == a0 && k < 40) begin tick(1); k++; end
    check("t1_aval_timeout", {31'd0, aval_cnt == a0}, 32'd0);
    check("t1_aq", 32'(aQ), 32'hBEEF);
    force_en = 1'b0;
    check("t1_nstrobe", 32'(slog.size()), 32'd1);
    check("t1_kind", 32'(slog[0].kind), 32'(OP_RD));
    check("t1_addr", 32'(slog[0].a), 32'h001234);
    check("t1_latency", 32'(last_aval_cyc - slog[0].cyc), 32'(TQ));
    tick(3);
    check("t1_aq_hold", 32'(aQ), 32'hBEEF);
    tick(10);

    // 2: refresh, A write and B read in the same cycle
    slog.delete();
    rfReq = 1'b1; aWr = 1'b1; aA = 24'h000010; aD = 16'h5A5A;
    bReq = 1'b1; bWe = 1'b0; bA = 24'h000777; bD = 16'h0;
    tick(1);
    rfReq = 1'b0; aWr = 1'b0; aA = 24'hFFFFFF; aD = 16'h0;
    k = 0;
    got = 0;
    while (!(slog.size() >= 3 && got) && k < 60) begin
      tick(1);
      k++;
      if (bAck) begin
        got  = 1;
        bq_s = bQ;
        bReq = 1'b0;
      end
    end
    check("t2_timeout", {31'd0, got && slog.size() >= 3}, 32'd1);
    tick(20);
    check("t2_nstrobe", 32'(slog.size()), 32'd3);
    check("t2_kind0", 32'(slog[0].kind), 32'(OP_RF));
    check("t2_kind1", 32'(slog[1].kind), 32'(OP_WR));
    check("t2_kind2", 32'(slog[2].kind), 32'(OP_RD));
    check("t2_gap01", 32'(slog[1].cyc - slog[0].cyc), 32'(PERIOD));
    check("t2_gap12", 32'(slog[2].cyc - slog[1].cyc), 32'(PERIOD));
    check("t2_wr_addr", 32'(slog[1].a), 32'h10);
    check("t2_wr_data", 32'(slog[1].d), 32'h5A5A);
    check("t2_b_addr", 32'(slog[2].a), 32'h777);
    check("t2_bq", 32'(bq_s), 32'(model_q(24'h000777)));

    // 3: B read held until bAck, then dropped
    slog.delete();
    b0 = back_cnt;
    bWe = 1'b0; bA = 24'h03FFFF; bD = 16'h1234; bReq = 1'b1;
    k = 0;
    got = 0;
    while (!got && k < 40) begin
      tick(1);
      k++;
      if (bAck) begin
        got  = 1;
        bq_s = bQ;
        bReq = 1'b0;
      end
    end
    check("t3_back_timeout", {31'd0, got}, 32'd1);
    tick(30);
    check("t3_nstrobe", 32'(slog.size()), 32'd1);
    check("t3_kind", 32'(slog[0].kind), 32'(OP_RD));
    check("t3_addr", 32'(slog[0].a), 32'h03FFFF);
    check("t3_latency", 32'(last_back_cyc - slog[0].cyc), 32'(TQ));
    check("t3_bq", 32'(bq_s), 32'(model_q(24'h03FFFF)));
    check("t3_nack", 32'(back_cnt - b0), 32'd1);

    // 4: A read overwritten by A write while busy; A read landing on the clear cycle
    slog.delete();
    a0 = aval_cnt;
    rfReq = 1'b1;
    tick(1);
    rfReq = 1'b0;
    tick(1);
    pulse_a(1'b0, 24'h000100, 16'h0000);
    tick(1);
    pulse_a(1'b1, 24'h000200, 16'h1111);
    k = 0;
    while (busy && k < 20) begin tick(1); k++; end
    check("t4_idle_timeout", {31'd0, busy}, 32'd0);
    pulse_a(1'b0, 24'h000300, 16'h0000);
    wait_strobes(3, 40, "t4");
    tick(20);
    check("t4_nstrobe", 32'(slog.size()), 32'd3);
    check("t4_kind0", 32'(slog[0].kind), 32'(OP_RF));
    check("t4_kind1", 32'(slog[1].kind), 32'(OP_WR));
    check("t4_wr_addr", 32'(slog[1].a), 32'h200);
    check("t4_wr_data", 32'(slog[1].d), 32'h1111);
    check("t4_kind2", 32'(slog[2].kind), 32'(OP_RD));
    check("t4_rd_addr", 32'(slog[2].a), 32'h300);
    check("t4_naval", 32'(aval_cnt - a0), 32'd1);
    check("t4_aq", 32'(aQ), 32'(model_q(24'h000300)));

    // 5: reset in the middle of a B read, with refresh and A pending
    slog.delete();
    b0 = back_cnt;
    bWe = 1'b0; bA = 24'h000042; bReq = 1'b1;
    wait_strobes(1, 20, "t5");
    tick(1);
    rfReq = 1'b1;
    tick(1);
    rfReq = 1'b0;
    aRd = 1'b1; aA = 24'h000055;
    tick(1);
    aRd = 1'b0;
    reset = 1'b0;
    bReq = 1'b0;
    tick(1);
    check("t5_state", 32'(dbgState), 32'(IDLE));
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_strobes", {29'd0, sdrRf, sdrRd, sdrWr}, 32'd0);
    check("t5_back", {31'd0, bAck}, 32'd0);
    reset = 1'b1;
    tick(40);
    check("t5_nstrobe", 32'(slog.size()), 32'd1);
    check("t5_nack", 32'(back_cnt - b0), 32'd0);

    // 6: randomized A reads, refresh pulses and back-to-back B traffic
    slog.delete();
    exp_q.delete();
    sb_on  = 1'b1;
    a_done = 1'b0;
    a0 = aval_cnt;
    nb = 0;
    fork
      begin
        logic [AW-1:0] ad;
        for (int i = 0; i < 40; i++) begin
          tick($urandom_range(30, 40));
          ad = AW'($urandom);
          exp_q.push_back(ad);
          pulse_a(1'b0, ad, 16'h0000);
        end
        tick(40);
        a_done = 1'b1;
      end
      begin
        int kb;
        kb = 0;
        bWe = 1'($urandom); bA = AW'($urandom); bD = DW'($urandom); bReq = 1'b1;
        while (!(a_done && !bReq) && kb < 5000) begin
          tick(1);
          kb++;
          if (bAck) begin
            nb++;
            if (a_done) begin
              bReq = 1'b0;
            end else begin
              bWe = 1'($urandom);
              bA  = AW'($urandom);
              bD  = DW'($urandom);
            end
          end
        end
        check("t6_b_timeout", {31'd0, bReq}, 32'd0);
      end
      begin
        while (!a_done) begin
          tick($urandom_range(50, 70));
          rfReq = 1'b1;
          tick(1);
          rfReq = 1'b0;
        end
      end
    join
    tick(20);
    sb_on = 1'b0;
    check("t6_naval", 32'(aval_cnt - a0), 32'd40);
    check("t6_exp_empty", 32'(exp_q.size()), 32'd0);
    check("t6_b_served", {31'd0, nb > 10}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
